// File: rtl/deser_fifo_rx.sv
// deser_fifo_rx: serial-to-parallel receiver with selectable bit order feeding a DEPTH-entry valid/ready FIFO
module deser_fifo_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  input  logic                       rx_en,
  input  logic                       l2b,
  input  logic                       clr,
  input  logic                       oe,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt,
  output logic                       overrun
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr_q, sr_d, sr_nx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ord_q, ord_d, ord_cur;
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             last, pop, full, push;
  assign dout_valid = oe && (lvl_q != '0);
  assign dout       = dout_valid ? mem_q[rp_q] : '0;
  assign level      = lvl_q;
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;
  always_comb begin
    ord_cur = (cnt_q == '0) ? l2b : ord_q;
    sr_nx   = ord_cur ? {sr_q[WIDTH-2:0], rx} : {rx, sr_q[WIDTH-1:1]};
    last    = rx_en && (cnt_q == CW'(WIDTH-1));
    pop     = dout_valid && dout_ready;
    full    = lvl_q == LW'(DEPTH);
    // a pop on the same edge frees the slot the completed word needs
    push    = last && (!full || pop);
    sr_d    = clr ? '0 : rx_en ? sr_nx : sr_q;
    cnt_d   = clr ? '0 : rx_en ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    ord_d   = clr ? 1'b0 : rx_en ? ord_cur : ord_q;
    wp_d    = clr ? '0 : push ? wp_q + 1'b1 : wp_q;
    rp_d    = clr ? '0 : pop ? rp_q + 1'b1 : rp_q;
    lvl_d   = clr ? '0 : (push && !pop) ? lvl_q + 1'b1 : (pop && !push) ? lvl_q - 1'b1 : lvl_q;
    ovr_d   = !clr && (ovr_q || (last && !push));
    mem_d   = mem_q;
    if (push && !clr) mem_d[wp_q] = sr_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ord_q <= 1'b0;
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      ovr_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      ord_q <= ord_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
      ovr_q <= ovr_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_deser_fifo_rx.sv
// tb_deser_fifo_rx: vector table, directed corner sequences and random traffic against a queue-based model
module tb_deser_fifo_rx;
  localparam int W = 8;
  localparam int D = 4;
  logic       clk = 0, rst = 1, rx = 0, rx_en = 0, l2b = 0, clr = 0, oe = 0, dout_ready = 0;
  logic [7:0] dout;
  logic       dout_valid, overrun;
  logic [2:0] level, bit_cnt;
  int         errs = 0, checks = 0;
  logic [7:0] mq[$];
  bit         mb[$];
  bit         mord = 0, movr = 0;

  typedef struct {
    bit rx, en, lb, c, o, rd;
    logic [7:0] d;
    bit v;
    int lv, bc;
    bit ov;
  } vec_t;
  vec_t tv[$];

  deser_fifo_rx #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_en(rx_en), .l2b(l2b), .clr(clr), .oe(oe),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .level(level), .bit_cnt(bit_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // words are formed from the collected bit list, not from a shift register
  task automatic model_edge();
    bit popm;
    logic [7:0] w;
    if (clr) begin
      mq.delete(); mb.delete(); mord = 0; movr = 0;
    end else begin
      popm = oe && mq.size() > 0 && dout_ready;
      if (popm) void'(mq.pop_front());
      if (rx_en) begin
        if (mb.size() == 0) mord = l2b;
        mb.push_back(rx);
        if (mb.size() == W) begin
          w = '0;
          for (int i = 0; i < W; i++) if (mord) w[W-1-i] = mb[i]; else w[i] = mb[i];
          mb.delete();
          if (mq.size() < D) mq.push_back(w); else movr = 1;
        end
      end
    end
  endtask

  task automatic model_reset();
    mq.delete(); mb.delete(); mord = 0; movr = 0;
  endtask

  task automatic step(input bit r, input bit e, input bit lb, input bit c, input bit o, input bit rd);
    rx = r; rx_en = e; l2b = lb; clr = c; oe = o; dout_ready = rd;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp_model(input string tag);
    bit v;
    v = oe && mq.size() > 0;
    chk({tag, ".dout"}, dout, v ? mq[0] : 8'h00);
    chk({tag, ".valid"}, dout_valid, v);
    chk({tag, ".level"}, level, mq.size());
    chk({tag, ".bit_cnt"}, bit_cnt, mb.size());
    chk({tag, ".overrun"}, overrun, movr);
  endtask

  task automatic send_word(input logic [7:0] w, input bit ord, input bit rd, input bit rd_last);
    for (int i = 0; i < W; i++) step(ord ? w[W-1-i] : w[i], 1, ord, 0, 1, i == W-1 ? rd_last : rd);
  endtask

  function automatic vec_t mk(bit r, bit e, bit lb, bit rd, logic [7:0] d, bit v, int lv, int bc);
    vec_t t;
    t.rx = r; t.en = e; t.lb = lb; t.c = 0; t.o = 1; t.rd = rd;
    t.d = d; t.v = v; t.lv = lv; t.bc = bc; t.ov = 0;
    return t;
  endfunction

  logic [7:0] seq = 8'b10110010;
  logic [7:0] aw[5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
  logic [7:0] bw[5] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};

  initial begin
    // serial bits 1,0,1,1,0,0,1,0: LSB-first gives 4D, MSB-first with l2b toggled mid-word gives B2
    for (int i = 0; i < W; i++)
      tv.push_back(mk(seq[7-i], 1, 0, 1, i == 7 ? 8'h4D : 8'h00, i == 7, i == 7 ? 1 : 0, i == 7 ? 0 : i+1));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0));
    for (int i = 0; i < W; i++)
      tv.push_back(mk(seq[7-i], 1, i < 3, 1, i == 7 ? 8'hB2 : 8'h00, i == 7, i == 7 ? 1 : 0, i == 7 ? 0 : i+1));
    tv.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 0));

    #12;
    chk("rst.dout", dout, 0);
    chk("rst.valid", dout_valid, 0);
    chk("rst.level", level, 0);
    chk("rst.bit_cnt", bit_cnt, 0);
    chk("rst.overrun", overrun, 0);
    rst = 0;

    for (int k = 0; k < tv.size(); k++) begin
      step(tv[k].rx, tv[k].en, tv[k].lb, tv[k].c, tv[k].o, tv[k].rd);
      chk($sformatf("vec%0d.dout", k), dout, tv[k].d);
      chk($sformatf("vec%0d.valid", k), dout_valid, tv[k].v);
      chk($sformatf("vec%0d.level", k), level, tv[k].lv);
      chk($sformatf("vec%0d.bit_cnt", k), bit_cnt, tv[k].bc);
      chk($sformatf("vec%0d.overrun", k), overrun, tv[k].ov);
    end

    for (int i = 0; i < 5; i++) send_word(aw[i], 0, 0, 0);
    chk("ovf.level", level, 4);
    chk("ovf.overrun", overrun, 1);
    chk("ovf.dout", dout, 8'hA1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1, 1);
      chk($sformatf("drain%0d.dout", k), dout, k < 3 ? aw[k+1] : 8'h00);
      chk($sformatf("drain%0d.level", k), level, 3-k);
    end
    step(0, 0, 0, 1, 1, 0);
    chk("clr.overrun", overrun, 0);
    cmp_model("after_ovf");

    for (int i = 0; i < 4; i++) send_word(bw[i], 0, 0, 0);
    send_word(bw[4], 0, 0, 1);
    chk("fullpop.level", level, 4);
    chk("fullpop.overrun", overrun, 0);
    chk("fullpop.dout", dout, 8'hB2);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1, 1);
      chk($sformatf("fpdrain%0d.dout", k), dout, k < 3 ? bw[k+2] : 8'h00);
    end
    cmp_model("after_fullpop");

    send_word(8'hC1, 1, 0, 0);
    send_word(8'hC2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("oe0.dout", dout, 0);
    chk("oe0.valid", dout_valid, 0);
    chk("oe0.level", level, 2);
    step(0, 0, 0, 0, 1, 0);
    chk("oe1.dout", dout, 8'hC1);
    chk("oe1.valid", dout_valid, 1);
    chk("oe1.level", level, 2);

    for (int i = 0; i < 3; i++) step(i[0], 1, 0, 0, 1, 0);
    #3 rst = 1;
    #1;
    chk("arst.bit_cnt", bit_cnt, 0);
    chk("arst.dout", dout, 0);
    chk("arst.valid", dout_valid, 0);
    chk("arst.level", level, 0);
    model_reset();
    #1 rst = 0;
    send_word(8'h5C, 0, 0, 0);
    chk("postrst.dout", dout, 8'h5C);
    chk("postrst.level", level, 1);
    chk("postrst.bit_cnt", bit_cnt, 0);
    send_word(8'h3E, 1, 0, 0);
    send_word(8'h71, 0, 0, 0);
    chk("pre_clr.level", level, 3);
    step(1, 1, 0, 1, 1, 1);
    chk("clr3.level", level, 0);
    chk("clr3.overrun", overrun, 0);
    chk("clr3.bit_cnt", bit_cnt, 0);
    cmp_model("after_clr");

    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
           $urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0);
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
